moore_first_eg: RTL and testbench

MOORE_FIRST_EG -- requirements
Module: moore_first_eg

---
 rtl/moore_first_eg_pkg.sv | 17 +
 rtl/moore_first_eg.sv | 47 ++++
 tb/tb_moore_first_eg.sv | 128 ++++++++++++
 3 files changed

// File: rtl/moore_first_eg_pkg.sv
// Shared definitions for the 1011 Moore sequence detector: state encoding
// and the fixed detection pattern.
package moore_first_eg_pkg;

  // Binary state encoding, 0..4; codes 5..7 are unreachable.
  typedef enum logic [2:0] {
    S0 = 3'd0,  // idle / no match
    S1 = 3'd1,  // seen "1"
    S2 = 3'd2,  // seen "10"
    S3 = 3'd3,  // seen "101"
    S4 = 3'd4   // seen "1011" -> detect
  } state_e;

  // Pattern in arrival order, MSB first.
  localparam logic [3:0] PATTERN = 4'b1011;

endpackage : moore_first_eg_pkg

// File: rtl/moore_first_eg.sv
// Moore overlapping detector for serial sequence 1,0,1,1 on x.
// y is decoded from the registered state only, so it rises after the edge
// that samples the final 1 and never follows x combinationally.
module moore_first_eg
  import moore_first_eg_pkg::*;
(
  input  logic clk,
  input  logic rst,   // asynchronous, active-low
  input  logic x,
  output logic y
);

  state_e state_q;
  state_e state_d;

  // State register; asynchronous active-low reset forces S0.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S0;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; the advance condition in each state compares x with the
  // next pattern bit, and mismatches fall back to the longest matching suffix.
  always_comb begin
    state_d = S0;
    case (state_q)
      S0: state_d = (x == PATTERN[3]) ? S1 : S0;
      S1: state_d = (x == PATTERN[2]) ? S2 : S1;
      S2: state_d = (x == PATTERN[1]) ? S3 : S0;
      S3: state_d = (x == PATTERN[0]) ? S4 : S2;
      S4: state_d = x ? S1 : S2;
      default: state_d = S0;  // illegal encodings recover to idle
    endcase
  end

  // Output decode: detect flag only in S4.
  always_comb begin
    y = 1'b0;
    if (state_q == S4) begin
      y = 1'b1;
    end
  end

endmodule : moore_first_eg

// File: tb/tb_moore_first_eg.sv
// Directed self-checking bench for moore_first_eg.
module tb_moore_first_eg;
  import moore_first_eg_pkg::*;

  logic clk;
  logic rst;
  logic x;
  logic y;

  int unsigned n_checks;
  int unsigned n_fail;

  moore_first_eg dut (
    .clk (clk),
    .rst (rst),
    .x   (x),
    .y   (y)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Compare y with the expected value.
  task automatic check_y(input logic exp, input string tag);
    n_checks++;
    assert (y === exp) else begin
      n_fail++;
      $error("FAIL %s: y=%b expected %b", tag, y, exp);
    end
  endtask

  // Compare the state register with the expected state.
  task automatic check_state(input state_e exp, input string tag);
    n_checks++;
    assert (dut.state_q === exp) else begin
      n_fail++;
      $error("FAIL %s: state=%0d expected %0d", tag, dut.state_q, exp);
    end
  endtask

  // Drive x at the falling edge, sample y 1 time unit after the rising edge.
  task automatic step(input logic xv, input logic exp, input string tag);
    @(negedge clk);
    x = xv;
    @(posedge clk);
    #1;
    check_y(exp, tag);
  endtask

  // Drive a stream (MSB first) and check y after every edge.
  task automatic run_seq(input int unsigned len, input logic [15:0] bits,
                         input logic [15:0] exp, input string tag);
    for (int unsigned i = 0; i < len; i++) begin
      step(bits[len-1-i], exp[len-1-i], $sformatf("%s[%0d]", tag, i + 1));
    end
  endtask

  // Two zeros return the detector to S0 from any legal state.
  task automatic flush(input string tag);
    step(1'b0, 1'b0, {tag, "_flush0"});
    step(1'b0, 1'b0, {tag, "_flush1"});
    check_state(S0, {tag, "_flush_s0"});
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst = 1'b0;
    x   = 1'b0;

    // Reset held, x toggling: y low, state S0, no clock needed initially.
    #1;
    check_y(1'b0, "rst_async_initial");
    for (int unsigned i = 0; i < 3; i++) begin
      step(~x, 1'b0, $sformatf("rst_hold_y[%0d]", i));
      check_state(S0, $sformatf("rst_hold_state[%0d]", i));
    end

    // Release reset between edges, then basic detection and one-cycle pulse.
    @(negedge clk);
    rst = 1'b1;
    run_seq(5, 16'b10110, 16'b00010, "basic");

    // Overlap: 1011011 pulses after bits 4 and 7.
    flush("ovl");
    run_seq(7, 16'b1011011, 16'b0001001, "overlap");

    // S4 with x=1 continues into a new match.
    flush("s4x1");
    run_seq(8, 16'b10111011, 16'b00010001, "s4_x1");

    // Run of ones must not false-trigger.
    flush("ones");
    run_seq(6, 16'b111011, 16'b000001, "ones_run");

    // S2 with x=0 returns to S0: never detects.
    flush("nodet");
    run_seq(5, 16'b10011, 16'b00000, "no_detect");

    // Reach S4, then assert reset between edges: y drops without a clock.
    flush("mid");
    run_seq(4, 16'b1011, 16'b0001, "pre_rst");
    #2;
    rst = 1'b0;
    #1;
    check_y(1'b0, "rst_mid_async_y");
    check_state(S0, "rst_mid_async_state");
    // x ignored while reset is held.
    step(1'b1, 1'b0, "rst_ignore_x1");
    step(1'b0, 1'b0, "rst_ignore_x0");
    step(1'b1, 1'b0, "rst_ignore_x1b");
    check_state(S0, "rst_ignore_state");
    @(negedge clk);
    rst = 1'b1;
    run_seq(4, 16'b1011, 16'b0001, "post_rst");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Safety timeout in case the run stalls.
  initial begin
    #100000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule : tb_moore_first_eg
